// File: rtl/nco_sincos.sv
// nco_sincos: phase-accumulator NCO with quarter-wave sin/cos lookup, 3-cycle valid-qualified pipeline
//   clk, rst_n (async active-low); i_freq/i_freq_load set step size; i_phase_offset shifts lookup phase;
//   i_sync clears the accumulator; i_valid advances it and emits one sample;
//   o_valid/o_phase/o_sin/o_cos carry the sample three cycles later and hold while o_valid=0.
module nco_sincos #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12,
  parameter int AMP_W   = 16,
  parameter int MAX     = 2**15-1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ACC_W-1:0]   i_freq,
  input  logic               i_freq_load,
  input  logic [PHASE_W-1:0] i_phase_offset,
  input  logic               i_sync,
  input  logic               i_valid,
  output logic               o_valid,
  output logic [PHASE_W-1:0] o_phase,
  output logic [AMP_W-1:0]   o_sin,
  output logic [AMP_W-1:0]   o_cos
);
  localparam int Q = 2**(PHASE_W-2);
  localparam logic [PHASE_W-2:0] QV = (PHASE_W-1)'(Q);
  function automatic logic [AMP_W-1:0] tbl(input int k);
    real v;
    v = real'(MAX) * $sin(2.0 * 3.14159265358979323846 * real'(k) / (2.0 ** PHASE_W));
    return AMP_W'($rtoi($floor(v + 0.5)));
  endfunction
  logic [AMP_W-1:0] rom [0:Q];
  for (genvar k = 0; k <= Q; k++) begin : g_rom
    localparam logic [AMP_W-1:0] V = tbl(k);
    assign rom[k] = V;
  end
  logic [ACC_W-1:0] acc, freq, base;
  logic [PHASE_W-1:0] p1, p2;
  logic [PHASE_W-2:0] ii, qi, a_s, a_c;
  logic [AMP_W-1:0] r_s, r_c;
  logic v1, v2;
  always_comb begin
    base = i_sync ? '0 : acc;
    ii   = {1'b0, p1[PHASE_W-3:0]};
    qi   = QV - ii;
    a_s  = p1[PHASE_W-2] ? qi : ii;
    a_c  = p1[PHASE_W-2] ? ii : qi;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      freq    <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      p1      <= '0;
      p2      <= '0;
      r_s     <= '0;
      r_c     <= '0;
      o_valid <= 1'b0;
      o_phase <= '0;
      o_sin   <= '0;
      o_cos   <= '0;
    end else begin
      freq    <= i_freq_load ? i_freq : freq;
      acc     <= i_valid ? base + freq : base;
      v1      <= i_valid;
      v2      <= v1;
      o_valid <= v2;
      if (i_valid) p1 <= base[ACC_W-1 -: PHASE_W] + i_phase_offset;
      if (v1) begin
        p2  <= p1;
        r_s <= rom[a_s];
        r_c <= rom[a_c];
      end
      if (v2) begin
        o_phase <= p2;
        o_sin   <= p2[PHASE_W-1] ? -r_s : r_s;
        o_cos   <= (p2[PHASE_W-1] ^ p2[PHASE_W-2]) ? -r_c : r_c;
      end
    end
  end
endmodule

// File: tb/tb_nco_sincos.sv
// tb_nco_sincos: randomized scoreboard bench for nco_sincos against a trigonometric reference model
module tb_nco_sincos;
  localparam int    MAXA = 32767;
  localparam real   PI   = 3.14159265358979323846;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_freq = '0;
  logic        i_freq_load = 1'b0;
  logic [11:0] i_phase_offset = '0;
  logic        i_sync = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_valid;
  logic [11:0] o_phase;
  logic [15:0] o_sin, o_cos;
  nco_sincos dut (
    .clk(clk), .rst_n(rst_n), .i_freq(i_freq), .i_freq_load(i_freq_load),
    .i_phase_offset(i_phase_offset), .i_sync(i_sync), .i_valid(i_valid),
    .o_valid(o_valid), .o_phase(o_phase), .o_sin(o_sin), .o_cos(o_cos)
  );
  always #5 clk = ~clk;
  typedef struct { int cyc; int ph; int s; int c; } exp_t;
  exp_t sb [$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] macc = '0, mfreq = '0;
  always @(posedge clk) cyc++;
  function automatic int ref_sin(input int p);
    return $rtoi($floor(real'(MAXA) * $sin(2.0 * PI * real'(p) / 4096.0) + 0.5));
  endfunction
  function automatic int ref_cos(input int p);
    return $rtoi($floor(real'(MAXA) * $cos(2.0 * PI * real'(p) / 4096.0) + 0.5));
  endfunction
  task automatic chk(input string name, input int act, input int exp_v, input int tol);
    n_cmp++;
    if (act - exp_v > tol || exp_v - act > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp_v, tol, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sample: got phase %0d with empty scoreboard at cycle %0d", o_phase, cyc);
      end else begin
        exp_t e;
        int tol;
        e = sb.pop_front();
        tol = (e.ph % 1024 == 0) ? 0 : 1;
        chk("latency_cycle", cyc, e.cyc, 0);
        chk("phase", int'(o_phase), e.ph, 0);
        chk("sin", int'($signed(o_sin)), e.s, tol);
        chk("cos", int'($signed(o_cos)), e.c, tol);
      end
    end
  end
  task automatic step(input bit v, input bit s, input bit l, input logic [31:0] f, input logic [11:0] off);
    logic [31:0] b;
    int p;
    i_valid = v; i_sync = s; i_freq_load = l; i_freq = f; i_phase_offset = off;
    b = s ? 32'd0 : macc;
    if (v) begin
      p = int'((b >> 20) + 32'(off)) & 4095;
      sb.push_back('{cyc + 3, p, ref_sin(p), ref_cos(p)});
      macc = b + mfreq;
    end else macc = b;
    if (l) mfreq = f;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 32'd0, 12'd0);
  endtask
  task automatic check_reset_state;
    chk("rst_o_valid", int'(o_valid), 0, 0);
    chk("rst_o_phase", int'(o_phase), 0, 0);
    chk("rst_o_sin", int'(o_sin), 0, 0);
    chk("rst_o_cos", int'(o_cos), 0, 0);
  endtask
  task automatic reset_pulse;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    macc = '0;
    mfreq = '0;
    i_valid = 0; i_sync = 0; i_freq_load = 0; i_freq = '0; i_phase_offset = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    @(posedge clk);
    #1;
    reset_pulse();
    step(1, 0, 0, 32'd0, 12'd0);
    idle(4);
    step(0, 0, 1, 32'h4000_0000, 12'd0);
    for (int k = 0; k < 8; k++) step(1, 0, 0, 32'd0, 12'd0);
    step(1, 1, 1, 32'h2000_0000, 12'd0);
    step(1, 0, 0, 32'd0, 12'd0);
    step(1, 0, 0, 32'd0, 12'd0);
    idle(4);
    step(0, 1, 1, 32'h4000_0000, 12'd0);
    step(1, 0, 0, 32'd0, 12'd1024);
    step(0, 0, 0, 32'd0, 12'd1024);
    step(1, 0, 0, 32'd0, 12'd1024);
    step(1, 0, 0, 32'd0, 12'd1024);
    step(0, 0, 0, 32'd0, 12'd1024);
    idle(4);
    step(0, 1, 1, 32'h0010_0000, 12'd0);
    for (int k = 0; k < 4100; k++) step(1, 0, 0, 32'd0, 12'd0);
    step(0, 1, 1, 32'h8000_0001, 12'd0);
    for (int k = 0; k < 24; k++) step(1, 0, 0, 32'd0, 12'd0);
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           32'($urandom), 12'($urandom));
    for (int k = 0; k < 5; k++) step(1, 0, 1, 32'h0123_4567, 12'd77);
    reset_pulse();
    step(1, 0, 0, 32'd0, 12'd0);
    idle(6);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending samples expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
